load_unload_seq: RTL
====================

# load_unload_seq

Parametrised load/decode/unload sequencer for the decoder datapath. One `start` rising edge triggers three phases:
- load NCH channel buffers of LOADCOUNT words each from the input FIFO;
- pulse the decoder core and wait for its completion;
- read UNLOADCOUNT words out to the output FIFO, then raise a stretched `done` for clock-domain hand-off.

It sits between the input FIFO, the decoder core and the output FIFO. Level-held `start` never retriggers it.

## Interface
Parameters:
- ADDRW, 9, address width; must satisfy 2^ADDRW ≥ max(LOADCOUNT, UNLOADCOUNT)
- LOADCOUNT, 17, words loaded per channel
- NCH, 2, channel count (≥1); CHW = max(1, clog2(NCH))
- UNLOADCOUNT, 16, words unloaded
- DONE_STRETCH, 10, `done` high time in clk cycles (≥2)

Ports:
- clk  in  1  decode clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request; only a rising edge seen in IDLE is acted on
- decode_done  in  1  decoder completion; sampled only in DEC_WAIT
- rd_en  out  1  input-FIFO read enable
- rd_addr  out  ADDRW  load word index
- rd_ch  out  CHW  load channel index
- load_en  out  1  rd_en delayed 1 cycle (FIFO data valid)
- load_addr  out  ADDRW  rd_addr delayed 1 cycle
- load_ch  out  CHW  rd_ch delayed 1 cycle
- decode_start  out  1  1-cycle decoder start pulse
- unload_rd_en  out  1  decoder-memory read enable
- unload_addr  out  ADDRW  unload word index
- unload_valid  out  1  unload_rd_en delayed 1 cycle (output-FIFO write)
- busy  out  1  high in every state except IDLE
- done  out  1  stretched completion flag

## Operation
- Edge detect: start_q is a register, start_rise = start & ~start_q; start_q resets to 0.
- States and transitions:
  - IDLE → LOAD on start_rise.
  - LOAD: rd_addr counts 0..LOADCOUNT-1, then wraps to 0 and rd_ch increments. After rd_ch = NCH-1 and rd_addr = LOADCOUNT-1 → DEC_START.
  - DEC_START: decode_start = 1 for one cycle → DEC_WAIT.
  - DEC_WAIT: stay until decode_done = 1 → UNLOAD.
  - UNLOAD: unload_addr counts 0..UNLOADCOUNT-1; at the last address → FINISH.
  - FINISH: one cycle; pushes a 1 into the done shift register → IDLE.
- All outputs are registered. rd_en/rd_addr/rd_ch are valid in the same cycles the state is LOAD.
- `start` is ignored outside IDLE. Returning to IDLE with `start` still high does not retrigger; a low-then-high transition is required.
- done = OR of a DONE_STRETCH-bit shift register fed by the FINISH flag. A new run may start while `done` is still high.
- Counters compare against parameter-1 and reset to 0 on wrap; they never exceed their parameter.
- Unused states decode to IDLE with all enables 0.

## Timing
- Reset (rst = 0 at a clk edge): state IDLE; every output 0, including delayed copies, shift register and start_q. Reset mid-run aborts immediately; after release, a fresh rising edge is required.
- start_rise sampled at edge k: rd_en = 1, rd_addr = 0, rd_ch = 0 after edge k+1.
- LOAD duration: NCH·LOADCOUNT cycles. load_en trails rd_en by exactly 1 cycle, so the last load word lands 1 cycle after LOAD ends.
- decode_start: high in the cycle right after the final rd_en cycle.
- decode_done: earliest acceptance is the first DEC_WAIT cycle. decode_done high during DEC_START is ignored.
- UNLOAD: unload_rd_en high for UNLOADCOUNT consecutive cycles; unload_valid trails by 1 cycle.
- done: rises 2 cycles after the last unload_rd_en cycle and stays high exactly DONE_STRETCH cycles.
- busy: falls in the cycle `done` rises.

## Structure
- Shared package: state encoding constants (IDLE, LOAD, DEC_START, DEC_WAIT, UNLOAD, FINISH, 3 bits) and the clog2 helper used for CHW.
- One sub-module: `pulse_stretch` (parameter N, synchronous active-low reset), which produces `done`.
- Everything else lives in one FSM plus counter and pipeline registers.

## Test plan
- Defaults. Pulse start for 1 cycle:
  - 34 rd_en cycles, addresses 0..16 for ch 0 then ch 1;
  - load_en trails by 1 cycle;
  - decode_start pulses once;
  - decode_done after 5 cycles gives 16 unload_valid cycles;
  - done high exactly 10 cycles.
- Hold start high for 200 cycles, decode_done tied high → exactly one complete run, no second LOAD until start toggles low then high.
- NCH=1, LOADCOUNT=4, UNLOADCOUNT=3 → rd_ch always 0; 4 load cycles, 3 unload cycles; decode_done high during DEC_START does not skip DEC_WAIT.
- Assert rst during LOAD at rd_addr = 7 → all outputs 0 next cycle; start still high after release causes no activity.
- New start edge while done is still high (cycle 3 of 10) → LOAD begins; done completes its 10 cycles undisturbed.
- decode_done held low for 1000 cycles → stays in DEC_WAIT with busy = 1 and every enable 0.

Source files
------------

// File: rtl/load_unload_seq_pkg.sv
// rtl/load_unload_seq_pkg.sv - state encoding and channel-width helper for load_unload_seq
package load_unload_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_DEC_START = 3'd2,
      ST_DEC_WAIT  = 3'd3,
      ST_UNLOAD    = 3'd4,
      ST_FINISH    = 3'd5
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int ch_width(input int nch);
      return (clog2(nch) < 1) ? 1 : clog2(nch);
   endfunction

endpackage

// File: rtl/load_unload_seq_pulse_stretch.sv
// rtl/load_unload_seq_pulse_stretch.sv - stretches a one-cycle pulse to N cycles for cross-domain hand-off
module pulse_stretch #(
   parameter int N = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pulse,
   output logic o_pulse
);

   logic [N-1:0] r_sr;
   logic         r_pulse;
   logic [N-1:0] w_next;

   assign w_next  = {r_sr[N-2:0], i_pulse};
   assign o_pulse = r_pulse;

   // r_pulse mirrors the OR of the shift register as it will be after this edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sr    <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sr    <= w_next;
         r_pulse <= |w_next;
      end
   end

endmodule

// File: rtl/load_unload_seq.sv
// rtl/load_unload_seq.sv - load/decode/unload sequencer between input FIFO, decoder core and output FIFO
module load_unload_seq
   import load_unload_seq_pkg::*;
#(
   parameter  int ADDRW        = 9,
   parameter  int LOADCOUNT    = 17,
   parameter  int NCH          = 2,
   parameter  int UNLOADCOUNT  = 16,
   parameter  int DONE_STRETCH = 10,
   localparam int CHW          = ch_width(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_decode_done,
   output logic             o_rd_en,
   output logic [ADDRW-1:0] o_rd_addr,
   output logic [CHW-1:0]   o_rd_ch,
   output logic             o_load_en,
   output logic [ADDRW-1:0] o_load_addr,
   output logic [CHW-1:0]   o_load_ch,
   output logic             o_decode_start,
   output logic             o_unload_rd_en,
   output logic [ADDRW-1:0] o_unload_addr,
   output logic             o_unload_valid,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [ADDRW-1:0] LOAD_LAST   = ADDRW'(LOADCOUNT - 1);
   localparam logic [ADDRW-1:0] UNLOAD_LAST = ADDRW'(UNLOADCOUNT - 1);
   localparam logic [CHW-1:0]   CH_LAST     = CHW'(NCH - 1);

   state_t           r_state;
   logic             r_start_q;
   logic             r_armed;
   logic             r_rise;
   logic             r_rd_en;
   logic [ADDRW-1:0] r_rd_addr;
   logic [CHW-1:0]   r_rd_ch;
   logic             r_load_en;
   logic [ADDRW-1:0] r_load_addr;
   logic [CHW-1:0]   r_load_ch;
   logic             r_decode_start;
   logic             r_unload_rd_en;
   logic [ADDRW-1:0] r_unload_addr;
   logic             r_unload_valid;
   logic             r_busy;
   logic             w_start_rise;
   logic             w_finish;
   logic             w_done;

   // r_armed keeps a start held high across reset from counting as a fresh edge
   assign w_start_rise = i_start & ~r_start_q & r_armed;
   assign w_finish     = (r_state == ST_FINISH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_start_q      <= 1'b0;
         r_armed        <= 1'b0;
         r_rise         <= 1'b0;
         r_rd_en        <= 1'b0;
         r_rd_addr      <= '0;
         r_rd_ch        <= '0;
         r_load_en      <= 1'b0;
         r_load_addr    <= '0;
         r_load_ch      <= '0;
         r_decode_start <= 1'b0;
         r_unload_rd_en <= 1'b0;
         r_unload_addr  <= '0;
         r_unload_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_start_q      <= i_start;
         if (!i_start) r_armed <= 1'b1;
         r_rise         <= w_start_rise && (r_state == ST_IDLE);
         r_load_en      <= r_rd_en;
         r_load_addr    <= r_rd_addr;
         r_load_ch      <= r_rd_ch;
         r_unload_valid <= r_unload_rd_en;
         case (r_state)
            ST_IDLE: begin
               if (r_rise) begin
                  r_state   <= ST_LOAD;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                  r_rd_ch   <= '0;
                  r_busy    <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (r_rd_addr == LOAD_LAST) begin
                  r_rd_addr <= '0;
                  if (r_rd_ch == CH_LAST) begin
                     r_state        <= ST_DEC_START;
                     r_rd_en        <= 1'b0;
                     r_rd_ch        <= '0;
                     r_decode_start <= 1'b1;
                  end else begin
                     r_rd_ch <= r_rd_ch + CHW'(1);
                  end
               end else begin
                  r_rd_addr <= r_rd_addr + ADDRW'(1);
               end
            end
            ST_DEC_START: begin
               r_state        <= ST_DEC_WAIT;
               r_decode_start <= 1'b0;
            end
            ST_DEC_WAIT: begin
               if (i_decode_done) begin
                  r_state        <= ST_UNLOAD;
                  r_unload_rd_en <= 1'b1;
                  r_unload_addr  <= '0;
               end
            end
            ST_UNLOAD: begin
               if (r_unload_addr == UNLOAD_LAST) begin
                  r_state        <= ST_FINISH;
                  r_unload_rd_en <= 1'b0;
                  r_unload_addr  <= '0;
               end else begin
                  r_unload_addr <= r_unload_addr + ADDRW'(1);
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state        <= ST_IDLE;
               r_rd_en        <= 1'b0;
               r_decode_start <= 1'b0;
               r_unload_rd_en <= 1'b0;
               r_busy         <= 1'b0;
            end
         endcase
      end
   end

   pulse_stretch #(
      .N(DONE_STRETCH)
   ) u_done_stretch (
      .clk    (clk),
      .rst    (rst),
      .i_pulse(w_finish),
      .o_pulse(w_done)
   );

   assign o_rd_en        = r_rd_en;
   assign o_rd_addr      = r_rd_addr;
   assign o_rd_ch        = r_rd_ch;
   assign o_load_en      = r_load_en;
   assign o_load_addr    = r_load_addr;
   assign o_load_ch      = r_load_ch;
   assign o_decode_start = r_decode_start;
   assign o_unload_rd_en = r_unload_rd_en;
   assign o_unload_addr  = r_unload_addr;
   assign o_unload_valid = r_unload_valid;
   assign o_busy         = r_busy;
   assign o_done         = w_done;

endmodule
